// File: rtl/dvp_pixel_packer.sv
// dvp_pixel_packer: DVP capture front-end, packs BPP bus words per pixel.
// Define DVP_PACKER_STATS_EN to build the frame_w/frame_h measurement.
module dvp_pixel_packer #(
  parameter int DIN_W       = 8,
  parameter int BPP         = 2,
  parameter int SKIP_FRAMES = 10,
  parameter int CNT_W       = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [DIN_W-1:0]       din,
  input  logic                   init_done,
  input  logic                   capture_en,
  input  logic                   msb_first,
  output logic [DIN_W*BPP-1:0]   pix_data,
  output logic                   pix_vld,
  output logic                   pix_sof,
  output logic                   line_end,
  output logic                   line_err,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       frame_w,
  output logic [CNT_W-1:0]       frame_h
);

  localparam int PW = DIN_W * BPP;
  localparam int IW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [IW-1:0] LAST = IW'(BPP - 1);
  localparam logic [7:0] SKIP_N = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ACTIVE,
    DROP
  } state_e;

  state_e           state_q;
  logic             vs_r, vs_p;
  logic             hr_r, hr_p;
  logic [DIN_W-1:0] din_r;
  logic             started_q;
  logic [7:0]       skip_cnt_q;
  logic [IW-1:0]    idx_q;
  logic [PW-1:0]    acc_q;
  logic             pend_q;
  logic             pend_sof_q;
  logic             arm_q;
  logic             fd_p_q;
  logic [PW-1:0]    pix_data_q;
  logic             pix_vld_q;
  logic             pix_sof_q;
  logic             line_end_q;
  logic             line_err_q;
  logic             frame_done_q;
  logic             vs_rise;
  logic [IW-1:0]    slot;
  state_e           next_st;

  assign vs_rise = vs_r & ~vs_p;
  assign slot    = msb_first ? (LAST - idx_q) : idx_q;
  assign next_st = capture_en ? ACTIVE : DROP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r  <= 1'b0;
      vs_p  <= 1'b0;
      hr_r  <= 1'b0;
      hr_p  <= 1'b0;
      din_r <= '0;
    end else begin
      vs_r  <= vsync;
      vs_p  <= vs_r;
      hr_r  <= href;
      hr_p  <= hr_r;
      din_r <= din;
    end
  end

  // Pixels and frame_done leave through one extra register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      started_q    <= 1'b0;
      skip_cnt_q   <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      pend_q       <= 1'b0;
      pend_sof_q   <= 1'b0;
      arm_q        <= 1'b0;
      fd_p_q       <= 1'b0;
      pix_data_q   <= '0;
      pix_vld_q    <= 1'b0;
      pix_sof_q    <= 1'b0;
      line_end_q   <= 1'b0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pix_vld_q    <= pend_q;
      pix_sof_q    <= pend_q & pend_sof_q;
      frame_done_q <= fd_p_q;
      if (pend_q) pix_data_q <= acc_q;
      pend_q     <= 1'b0;
      fd_p_q     <= 1'b0;
      line_end_q <= 1'b0;
      line_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (init_done) started_q <= 1'b1;
          if (started_q) state_q <= SKIP;
        end
        SKIP: begin
          if (vs_rise) begin
            if (skip_cnt_q == SKIP_N) begin
              state_q <= next_st;
              arm_q   <= 1'b1;
              idx_q   <= '0;
            end else if (skip_cnt_q != '1) begin
              skip_cnt_q <= skip_cnt_q + 8'd1;
            end
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            fd_p_q  <= 1'b1;
            state_q <= next_st;
            arm_q   <= 1'b1;
            idx_q   <= '0;
          end else if (hr_r) begin
            for (int s = 0; s < BPP; s++) begin
              if (slot == IW'(s)) acc_q[s*DIN_W +: DIN_W] <= din_r;
            end
            if (idx_q == LAST) begin
              pend_q     <= 1'b1;
              pend_sof_q <= arm_q;
              arm_q      <= 1'b0;
              idx_q      <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (hr_p) begin
            line_end_q <= 1'b1;
            line_err_q <= (idx_q != '0);
            idx_q      <= '0;
          end
        end
        DROP: begin
          if (vs_rise) begin
            state_q <= next_st;
            arm_q   <= 1'b1;
            idx_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_vld    = pix_vld_q;
  assign pix_sof    = pix_sof_q;
  assign line_end   = line_end_q;
  assign line_err   = line_err_q;
  assign frame_done = frame_done_q;

`ifdef DVP_PACKER_STATS_EN
  logic             act;
  logic             pix_done;
  logic             line_done;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [CNT_W-1:0] line_cnt_q;
  logic [CNT_W-1:0] last_w_q;
  logic [CNT_W-1:0] snap_w_q;
  logic [CNT_W-1:0] snap_h_q;
  logic [CNT_W-1:0] frame_w_q;
  logic [CNT_W-1:0] frame_h_q;

  assign act       = (state_q == ACTIVE);
  assign pix_done  = act & ~vs_rise & hr_r & (idx_q == LAST);
  assign line_done = act & ~vs_rise & ~hr_r & hr_p;

  // Snapshot at the boundary, publish one cycle later with frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      last_w_q   <= '0;
      snap_w_q   <= '0;
      snap_h_q   <= '0;
      frame_w_q  <= '0;
      frame_h_q  <= '0;
    end else begin
      if (act && vs_rise) begin
        snap_w_q   <= last_w_q;
        snap_h_q   <= line_cnt_q;
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
        last_w_q   <= '0;
      end else if (line_done) begin
        last_w_q  <= pix_cnt_q;
        pix_cnt_q <= '0;
        if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + 1'b1;
      end else if (pix_done && pix_cnt_q != '1) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
      end
      if (fd_p_q) begin
        frame_w_q <= snap_w_q;
        frame_h_q <= snap_h_q;
      end
    end
  end

  assign frame_w = frame_w_q;
  assign frame_h = frame_h_q;
`else
  assign frame_w = '0;
  assign frame_h = '0;
`endif

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// tb_dvp_pixel_packer: random frames checked against a frame-level model.
// Honours DVP_PACKER_STATS_EN for the frame_w/frame_h expectations.
module tb_dvp_pixel_packer;

  localparam int DIN_W = 8;
  localparam int BPP   = 2;
  localparam int SKIP  = 2;
  localparam int CNT_W = 12;
  localparam int PW    = DIN_W * BPP;
`ifdef DVP_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vsync = 1'b0;
  logic             href = 1'b0;
  logic [DIN_W-1:0] din = '0;
  logic             init_done = 1'b0;
  logic             capture_en = 1'b0;
  logic             msb_first = 1'b1;
  logic [PW-1:0]    pix_data;
  logic             pix_vld;
  logic             pix_sof;
  logic             line_end;
  logic             line_err;
  logic             frame_done;
  logic [CNT_W-1:0] frame_w;
  logic [CNT_W-1:0] frame_h;

  dvp_pixel_packer #(
    .DIN_W(DIN_W),
    .BPP(BPP),
    .SKIP_FRAMES(SKIP),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .href(href),
    .din(din),
    .init_done(init_done),
    .capture_en(capture_en),
    .msb_first(msb_first),
    .pix_data(pix_data),
    .pix_vld(pix_vld),
    .pix_sof(pix_sof),
    .line_end(line_end),
    .line_err(line_err),
    .frame_done(frame_done),
    .frame_w(frame_w),
    .frame_h(frame_h)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame-level model
  bit            started = 1'b0;
  int            nrise = 0;
  bit            cap_cur = 1'b0;
  logic [PW-1:0] exp_pix[$];
  int            exp_lines, exp_errs, exp_w, exp_h, exp_first_cyc;

  // observed events
  logic [PW-1:0]    got_pix[$];
  int               got_sof, got_le, got_err, err_alone, got_fd;
  int               fd_cyc, got_first_cyc, vs_cyc;
  logic             sof_first;
  logic [CNT_W-1:0] got_w, got_h;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_vld) begin
        if (got_pix.size() == 0) begin
          got_first_cyc = cyc;
          sof_first     = pix_sof;
        end
        got_pix.push_back(pix_data);
      end
      if (pix_sof) got_sof++;
      if (line_end) got_le++;
      if (line_err) got_err++;
      if (line_err && !line_end) err_alone++;
      if (frame_done) begin
        got_fd++;
        fd_cyc = cyc;
        got_w  = frame_w;
        got_h  = frame_h;
      end
    end
  end

  task automatic clear_all();
    exp_pix.delete();
    got_pix.delete();
    exp_lines = 0; exp_errs = 0; exp_w = 0; exp_h = 0;
    got_sof = 0; got_le = 0; got_err = 0; err_alone = 0; got_fd = 0;
    sof_first = 1'b0;
  endtask

  task automatic check_frame(input bit pc);
    int n;
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    check("npix", got_pix.size(), exp_pix.size());
    for (int i = 0; i < n; i++) check("pix", got_pix[i], exp_pix[i]);
    check("sof_cnt", got_sof, (exp_pix.size() > 0) ? 1 : 0);
    if (exp_pix.size() > 0 && got_pix.size() > 0) begin
      check("sof_first", sof_first, 1);
      check("pix_lat", got_first_cyc - exp_first_cyc, 3);
    end
    check("line_end", got_le, exp_lines);
    check("line_err", got_err, exp_errs);
    check("err_alone", err_alone, 0);
    check("frame_done", got_fd, pc ? 1 : 0);
    if (pc && got_fd == 1) begin
      check("fd_lat", fd_cyc - vs_cyc, 3);
      check("frame_w", got_w, STATS ? exp_w : 0);
      check("frame_h", got_h, STATS ? exp_h : 0);
    end
  endtask

  task automatic vs_edge();
    bit prev_cap;
    vsync  = 1'b1;
    vs_cyc = cyc;
    prev_cap = cap_cur;
    if (started) begin
      nrise++;
      cap_cur = (nrise > SKIP) && capture_en;
    end else begin
      cap_cur = 1'b0;
    end
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    check_frame(prev_cap);
    clear_all();
  endtask

  task automatic send_line(input int n, input bit rgb);
    logic [PW-1:0] acc;
    int k, full;
    acc = '0; k = 0; full = 0;
    for (int i = 0; i < n; i++) begin
      logic [DIN_W-1:0] w;
      if (rgb) w = (i == 0) ? 8'hF8 : 8'h1F;
      else     w = DIN_W'($urandom);
      din  = w;
      href = 1'b1;
      if (cap_cur) begin
        if (msb_first) acc = (acc << DIN_W) | PW'(w);
        else           acc = acc | (PW'(w) << (DIN_W * k));
        k++;
        if (k == BPP) begin
          if (exp_pix.size() == 0) exp_first_cyc = cyc;
          exp_pix.push_back(acc);
          acc = '0; k = 0; full++;
        end
      end
      @(negedge clk);
    end
    href = 1'b0;
    if (cap_cur) begin
      exp_lines++;
      if (k != 0) exp_errs++;
      exp_w = full;
      exp_h++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_init();
    init_done = 1'b1;
    @(negedge clk);
    init_done = 1'b0;
    started   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_frame();
    int nl;
    vs_edge();
    msb_first = 1'($urandom);
    nl = $urandom_range(1, 4);
    for (int l = 0; l < nl; l++) begin
      send_line($urandom_range(1, 12), 1'b0);
      if (l == 0) capture_en = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    clear_all();
    repeat (3) @(negedge clk);
    check("rst_outs", {pix_data, pix_vld, pix_sof, line_end, line_err,
                       frame_done, frame_w, frame_h}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // no init_done yet: frames are ignored
    vs_edge();
    send_line(6, 1'b0);
    capture_en = 1'b1;
    pulse_init();

    vs_edge(); send_line(4, 1'b0);
    vs_edge(); send_line(4, 1'b0);

    // first captured frame: RGB565 msb-first plus a partial line
    vs_edge();
    msb_first = 1'b1;
    send_line(2, 1'b1);
    check("rgb_msb", (got_pix.size() > 0) ? got_pix[0] : '0, 16'hF81F);
    send_line(5, 1'b0);

    vs_edge();
    msb_first = 1'b0;
    send_line(2, 1'b1);
    check("rgb_lsb", (got_pix.size() > 0) ? got_pix[0] : '0, 16'h1FF8);

    // geometry frame
    vs_edge();
    msb_first = 1'b1;
    for (int l = 0; l < 6; l++) send_line(16, 1'b0);
    vs_edge();
    check("geom_w", frame_w, STATS ? 8 : 0);
    check("geom_h", frame_h, STATS ? 6 : 0);

    for (int f = 0; f < 14; f++) rand_frame();

    // reset in the middle of a captured line
    capture_en = 1'b1;
    vs_edge();
    send_line(6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      din  = DIN_W'($urandom);
      href = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", {pix_data, pix_vld, pix_sof, line_end, line_err,
                      frame_done, frame_w, frame_h}, 0);
    href    = 1'b0;
    started = 1'b0;
    nrise   = 0;
    cap_cur = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_all();
    repeat (2) @(negedge clk);

    vs_edge(); send_line(6, 1'b0);
    vs_edge(); send_line(6, 1'b0);
    pulse_init();
    for (int f = 0; f < 5; f++) begin
      vs_edge();
      send_line($urandom_range(2, 10), 1'b0);
      send_line($urandom_range(2, 10), 1'b0);
    end
    vs_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_pixel_packer.md
# dvp_pixel_packer

Parametrised DVP camera capture front-end that sits between the sensor pins (pclk domain) and the DDR3 write path. It waits for sensor initialisation, discards a configurable number of start-up frames, and gates capture per frame. It then packs `BPP` consecutive `DIN_W`-bit bus words into one pixel word with selectable byte order, and emits start-of-frame, line-end and frame-done markers. Optional frame-geometry measurement reports the width and height of the last captured frame.

## Interface
Parameters:
- `DIN_W`, 8, sensor data bus width in bits.
- `BPP`, 2, bus words per pixel (1..4); pixel width is `DIN_W*BPP`.
- `SKIP_FRAMES`, 10, vsync rising edges discarded after `init_done` before capture may start (0..255).
- `CNT_W`, 12, width of the pixel and line counters.

Ports:
- `clk` in 1: sensor pixel clock (pclk); the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `vsync` in 1: frame sync; a rising edge marks the frame boundary.
- `href` in 1: line valid.
- `din` in `DIN_W`: sensor data.
- `init_done` in 1: sensor configuration finished; sampled as a sticky start.
- `capture_en` in 1: capture request, sampled only at a frame boundary.
- `msb_first` in 1: 1 means the first word of a pixel lands in the MS slot; 0 means the LS slot. Static during a frame.
- `pix_data` out `DIN_W*BPP`: packed pixel.
- `pix_vld` out 1: one-cycle strobe, `pix_data` valid.
- `pix_sof` out 1: asserted together with `pix_vld` on the first pixel of a frame.
- `line_end` out 1: one-cycle pulse after each captured line ends.
- `line_err` out 1: one-cycle pulse when a line ends with a partial pixel.
- `frame_done` out 1: one-cycle pulse when a captured frame closes.
- `frame_w` out `CNT_W`: pixels in the last line of the last captured frame.
- `frame_h` out `CNT_W`: lines in the last captured frame.

## Operation
- Input stage: `vsync`, `href` and `din` are registered once (`vs_r`, `hr_r`, `din_r`). `vs_rise` = `vs_r` high while its previous value was low.
- The FSM has four states, and reset enters `IDLE`:
  - `IDLE`: a sticky `started` flag sets on `init_done`; go to `SKIP` when `started` is set.
  - `SKIP`: on `vs_rise`, if `skip_cnt == SKIP_FRAMES`, enter `ACTIVE` or `DROP` according to `capture_en`; otherwise increment `skip_cnt`.
  - `ACTIVE`: capture. On `vs_rise`, pulse `frame_done`, latch the statistics, then re-evaluate `capture_en` to enter `ACTIVE` or `DROP`.
  - `DROP`: emit no outputs. On `vs_rise`, re-evaluate `capture_en`.
- Packing (ACTIVE only):
  - `byte_idx` (0..BPP-1) advances on each cycle with `hr_r` high.
  - At index k, `din_r` goes to slot `BPP-1-k` when `msb_first=1`, or slot k when `msb_first=0`.
  - When k = BPP-1, register `pix_data` and strobe `pix_vld`.
- `hr_r` falling (1→0) in ACTIVE:
  - Pulse `line_end`.
  - If `byte_idx != 0`, pulse `line_err` in the same cycle and discard the partial pixel.
  - Clear `byte_idx`.
  - Increment `line_cnt`, and load `last_w` with `pix_cnt`.
  - `pix_cnt` resets on each line.
- `pix_sof` accompanies the first `pix_vld` after entering ACTIVE.
- Counters saturate at all-ones; they never wrap.
- `vs_rise` with `hr_r` high: the frame boundary takes priority. The in-flight pixel is dropped, with no `line_end` and no `line_err`.
- `capture_en` changes mid-frame have no effect until the next boundary.
- Reset mid-frame: all state, counters and outputs return to reset values and the FSM returns to `IDLE`. `init_done` must be seen again.

## Timing
- Reset values: `pix_data`=0, `pix_vld`=0, `pix_sof`=0, `line_end`=0, `line_err`=0, `frame_done`=0, `frame_w`=0, `frame_h`=0.
- Latency: the last word of a pixel present at `din` before edge t produces `pix_vld` high after edge t+2. `pix_data` holds until the next `pix_vld`.
- Maximum throughput is one pixel per BPP clocks. With BPP=1, `pix_vld` may be high on consecutive cycles.
- `line_end` occurs 2 cycles after `href` falls at the pins.
- `frame_done` and the `frame_w`/`frame_h` update occur 3 cycles after `vsync` rises at the pins.
- All outputs are registered. There is no back-pressure; the consumer must accept every `pix_vld`.

## Configuration
- `DVP_PACKER_STATS_EN`:
  - Defined: `frame_w`/`frame_h` are latched from `last_w`/`line_cnt` at each `frame_done`.
  - Undefined: the measurement counters are not built, `frame_w` and `frame_h` are tied to 0, and `line_end`/`line_err` are unaffected.

## Test plan
- Start-up skip: SKIP_FRAMES=2, `init_done` pulsed, `capture_en`=1, 4 frames -> first `pix_vld` in frame 3; no `pix_vld` before; `pix_sof` exactly once per captured frame.
- RGB565 packing: BPP=2, `msb_first`=1, words 0xF8,0x1F -> `pix_data`=0xF81F; with `msb_first`=0 -> 0x1FF8. Second word at pins before edge t gives `pix_vld` after t+2.
- Partial line: `href` high for 5 words, BPP=2 -> 2 `pix_vld`, then `line_end`=1 and `line_err`=1 in the same cycle.
- Frame gating: `capture_en` dropped mid-frame 4 -> frame 4 completes with `frame_done`; frame 5 produces zero `pix_vld`, `line_end` and `frame_done`.
- Geometry (macro defined): 640 words/line, BPP=2, 480 lines -> `frame_w`=320, `frame_h`=480 after `frame_done`; macro undefined -> both stay 0.
- Reset: `rst_n` low during line 100 -> all outputs 0 next cycle; after release, capture resumes only after `init_done` plus SKIP_FRAMES boundaries.
